// File: rtl/i2s_receiver_pkg.sv
// Purpose: shared audio configuration and I2S channel encoding for the RX and DAC paths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package i2s_receiver_pkg;

  localparam int AUDIO_BIT_WIDTH   = 24;
  localparam int AUDIO_SAMPLE_RATE = 44100;
  localparam int AUDIO_CLOCK       = 16934400;

  // Bit index counts 0..AUDIO_BIT_WIDTH inclusive (saturates at the width).
  localparam int BIT_INDEX_W = $clog2(AUDIO_BIT_WIDTH + 1);

  // LRCLK level encoding, shared with the DAC driver.
  typedef enum logic {
    I2S_LEFT  = 1'b0,
    I2S_RIGHT = 1'b1
  } i2s_channel_e;

  typedef logic [AUDIO_BIT_WIDTH-1:0] audio_word_t;

endpackage

// File: rtl/i2s_receiver_sync_edge_detect.sv
// Purpose: SYNC_STAGES-deep synchronisers for BCLK, LRCLK and data, plus BCLK rising-edge pulse.
// Latency: pin edge captured at edge N gives o_bclk_rise in the cycle after edge N+SYNC_STAGES-1.
// Backpressure: none; free-running, LR and data see exactly the same delay as BCLK.
module i2s_receiver_sync_edge_detect #(
  parameter int SYNC_STAGES = 2  // minimum 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bclk,
  input  logic i_lr,
  input  logic i_data,
  output logic o_bclk,
  output logic o_bclk_rise,
  output logic o_lr,
  output logic o_data
);

  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_lr_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_bclk_dly;

  // Shift all three pins through identical synchroniser chains; keep one extra BCLK copy for edge detect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_data_sync <= '0;
      r_bclk_dly  <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i_bclk};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], i_lr};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_data};
      r_bclk_dly  <= r_bclk_sync[SYNC_STAGES-1];
    end
  end

  assign o_bclk      = r_bclk_sync[SYNC_STAGES-1];
  assign o_bclk_rise = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_dly;
  assign o_lr        = r_lr_sync[SYNC_STAGES-1];
  assign o_data      = r_data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// Purpose: I2S slave receiver; oversamples BCLK/LRCLK/data, deserialises MSB-first words into a stereo pair.
// Latency: sample_valid high in the cycle after edge N+SYNC_STAGES for a right-LSB BCLK edge captured at edge N.
// Backpressure: none; one-cycle strobe per pair, outputs hold until next commit. Optional watchdog: I2S_RX_WATCHDOG_EN.
module i2s_receiver
  import i2s_receiver_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BCLK_TIMEOUT = 64
) (
  input  logic                       clock_16_934_400,
  input  logic                       reset_l,
  input  logic                       i2s_bit_clock,
  input  logic                       i2s_left_right_clock,
  input  logic                       i2s_data,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_left,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_right,
  output logic                       sample_valid,
  output logic                       rx_error
);

  logic w_bclk_level_unused;
  logic w_bclk_rise;
  logic w_lr;
  logic w_data;

  i2s_receiver_sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk       (clock_16_934_400),
    .i_rst_n     (reset_l),
    .i_bclk      (i2s_bit_clock),
    .i_lr        (i2s_left_right_clock),
    .i_data      (i2s_data),
    .o_bclk      (w_bclk_level_unused),
    .o_bclk_rise (w_bclk_rise),
    .o_lr        (w_lr),
    .o_data      (w_data)
  );

  audio_word_t            r_shift_reg;
  logic [BIT_INDEX_W-1:0] r_bit_index;
  i2s_channel_e           r_prev_lr;
  logic                   r_synced;
  logic                   r_have_left;
  audio_word_t            r_audio_left;
  audio_word_t            r_audio_right;
  logic                   r_sample_valid;

  audio_word_t            w_shift_next;
  logic [BIT_INDEX_W-1:0] w_index_next;
  logic                   w_lr_edge;
  logic                   w_commit_left;
  logic                   w_timeout;

  // Next shift-register/index values: place d at MSB-first slot, ignore bits past the word width.
  always_comb begin
    w_shift_next = r_shift_reg;
    w_index_next = r_bit_index;
    for (int i = 0; i < AUDIO_BIT_WIDTH; i++) begin
      if (r_bit_index == BIT_INDEX_W'(AUDIO_BIT_WIDTH - 1 - i)) begin
        w_shift_next[i] = w_data;
      end
    end
    if (r_bit_index < BIT_INDEX_W'(AUDIO_BIT_WIDTH)) begin
      w_index_next = r_bit_index + 1'b1;
    end
  end

  assign w_lr_edge     = (w_lr != r_prev_lr);
  assign w_commit_left = w_bclk_rise & w_lr_edge & r_synced & (r_prev_lr == I2S_LEFT);

  // Deserialiser and commit: all updates on bclk_rise, except watchdog loss-of-sync.
  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l) begin
      r_shift_reg    <= '0;
      r_bit_index    <= '0;
      r_prev_lr      <= I2S_LEFT;
      r_synced       <= 1'b0;
      r_have_left    <= 1'b0;
      r_audio_left   <= '0;
      r_audio_right  <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_bclk_rise) begin
        if (w_lr_edge) begin
          // The LSB slot of the outgoing channel arrives with the new LR level.
          if (r_synced) begin
            if (r_prev_lr == I2S_LEFT) begin
              r_audio_left <= w_shift_next;
              r_have_left  <= 1'b1;
            end else begin
              r_audio_right  <= w_shift_next;
              r_sample_valid <= r_have_left;
              r_have_left    <= 1'b0;
            end
          end
          r_shift_reg <= '0;
          r_bit_index <= '0;
          r_synced    <= 1'b1;
          r_prev_lr   <= i2s_channel_e'(w_lr);
        end else begin
          r_shift_reg <= w_shift_next;
          r_bit_index <= w_index_next;
        end
      end else if (w_timeout) begin
        r_synced    <= 1'b0;
        r_have_left <= 1'b0;
      end
    end
  end

  assign audio_left   = r_audio_left;
  assign audio_right  = r_audio_right;
  assign sample_valid = r_sample_valid;

`ifdef I2S_RX_WATCHDOG_EN
  localparam int WD_W = $clog2(BCLK_TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_rx_error;

  // Timeout fires only on the cycle the counter reaches BCLK_TIMEOUT.
  assign w_timeout = ~w_bclk_rise & (r_wd_cnt == WD_W'(BCLK_TIMEOUT - 1));

  // Cycles since last BCLK rise, saturating at the timeout.
  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l) begin
      r_wd_cnt <= '0;
    end else if (w_bclk_rise) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != WD_W'(BCLK_TIMEOUT)) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // Error flag: set on timeout, cleared by the next committed left word.
  always_ff @(posedge clock_16_934_400 or negedge reset_l) begin
    if (!reset_l) begin
      r_rx_error <= 1'b0;
    end else if (w_timeout) begin
      r_rx_error <= 1'b1;
    end else if (w_commit_left) begin
      r_rx_error <= 1'b0;
    end
  end

  assign rx_error = r_rx_error;
`else
  logic w_unused_watchdog;

  // Without the watchdog the receiver waits indefinitely for BCLK.
  assign w_timeout         = 1'b0;
  assign rx_error          = 1'b0;
  assign w_unused_watchdog = ^{BCLK_TIMEOUT, w_commit_left};
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
`timescale 1ns/1ps
module tb_i2s_receiver;
  import i2s_receiver_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_l = 1'b0;
  logic        bclk  = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic [23:0] audio_left;
  logic [23:0] audio_right;
  logic        sample_valid;
  logic        rx_error;

  always #5 clk = ~clk;

  i2s_receiver #(
    .SYNC_STAGES  (2),
    .BCLK_TIMEOUT (64)
  ) dut (
    .clock_16_934_400     (clk),
    .reset_l              (rst_l),
    .i2s_bit_clock        (bclk),
    .i2s_left_right_clock (lrclk),
    .i2s_data             (sdata),
    .audio_left           (audio_left),
    .audio_right          (audio_right),
    .sample_valid         (sample_valid),
    .rx_error             (rx_error)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  pair_t exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    strobes = 0;
  int    period  = 0;
  int    epoch   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One BCLK period of 8 system cycles; LR and data change while BCLK is low.
  task automatic send_bit(input logic lr, input logic d);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = d;
    wait_cyc(4);
    bclk  = 1'b1;
    wait_cyc(4);
  endtask

  // n-bit slot, MSB first; the final (LSB) bit goes out with the next channel's LR level.
  task automatic send_word(input logic ch, input logic [31:0] w, input int n, input logic nxt);
    for (int k = 0; k < n; k++) begin
      send_bit((k == n - 1) ? nxt : ch, w[n-1-k]);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_word(1'b0, l, n, 1'b1);
    send_word(1'b1, r, n, 1'b0);
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected pair.
  initial begin : monitor
    int    last_cyc;
    int    last_epoch;
    bit    have_last;
    bit    prev_vld;
    pair_t e;
    have_last  = 1'b0;
    prev_vld   = 1'b0;
    last_cyc   = 0;
    last_epoch = 0;
    forever begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        strobes++;
        check("strobe_not_back_to_back", 32'(prev_vld), 32'd0);
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("strobe_left", 32'(audio_left), 32'(e.l));
          check("strobe_right", 32'(audio_right), 32'(e.r));
        end
        if (period != 0 && have_last && last_epoch == epoch) begin
          check("strobe_period", 32'(cyc - last_cyc), 32'(period));
        end
        have_last  = 1'b1;
        last_cyc   = cyc;
        last_epoch = epoch;
      end
      prev_vld = (sample_valid === 1'b1);
    end
  end

  initial begin : stimulus
    int s0;

    // Reset state
    wait_cyc(3);
    check("rst_left", 32'(audio_left), 32'd0);
    check("rst_right", 32'(audio_right), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_error", 32'(rx_error), 32'd0);
    rst_l = 1'b1;

    // BCLK stopped: nothing happens
    s0 = strobes;
    wait_cyc(10000);
    check("idle_strobes", 32'(strobes - s0), 32'd0);
    check("idle_left", 32'(audio_left), 32'd0);
    check("idle_right", 32'(audio_right), 32'd0);

    // Start mid-left-word: partial dropped, right commits without strobe
    send_word(1'b0, 32'h0000_02A5, 10, 1'b1);
    send_word(1'b1, 32'h00AB_CDEF, 24, 1'b0);
    check("midframe_left_untouched", 32'(audio_left), 32'd0);
    check("midframe_right", 32'(audio_right), 32'h00AB_CDEF);
    check("midframe_no_strobe", 32'(strobes - s0), 32'd0);

    // Standard 24-bit frames, one strobe per 384 cycles
    epoch++;
    period = 384;
    for (int f = 0; f < 3; f++) begin
      push(24'h123456, 24'hABCDEF);
      send_frame(32'h0012_3456, 32'h00AB_CDEF, 24);
    end
    check("std_strobe_count", 32'(strobes - s0), 32'd3);
    period = 0;

    // 32-bit slots: extra bits ignored
    push(24'h800000, 24'h123456);
    send_frame(32'h8000_00FF, 32'h1234_56AB, 32);
    push(24'h7FFFFF, 24'h000001);
    send_frame(32'h7FFF_FF00, 32'h0000_01FF, 32);

    // 16-bit slots: left-justified, LSBs zero
    push(24'h7FFF00, 24'h800100);
    send_frame(32'h0000_7FFF, 32'h0000_8001, 16);
    push(24'h000100, 24'hFFFF00);
    send_frame(32'h0000_0001, 32'h0000_FFFF, 16);

    // Reset in the middle of a right word
    send_word(1'b0, 32'h0055_AA55, 24, 1'b1);
    for (int k = 0; k < 10; k++) send_bit(1'b1, k[0]);
    bclk = 1'b0;
    wait_cyc(2);
    rst_l = 1'b0;
    #1;
    check("midrst_left", 32'(audio_left), 32'd0);
    check("midrst_right", 32'(audio_right), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    check("midrst_error", 32'(rx_error), 32'd0);
    wait_cyc(5);
    rst_l = 1'b1;
    wait_cyc(2);
    s0 = strobes;
    for (int k = 0; k < 13; k++) send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check("postrst_left_untouched", 32'(audio_left), 32'd0);
    check("postrst_no_strobe", 32'(strobes - s0), 32'd0);
    push(24'h13579B, 24'h2468AC);
    send_frame(32'h0013_579B, 32'h0024_68AC, 24);
    check("postrst_strobe_count", 32'(strobes - s0), 32'd1);

    // BCLK stall
    bclk = 1'b0;
    wait_cyc(200);
`ifdef I2S_RX_WATCHDOG_EN
    check("wd_error_set", 32'(rx_error), 32'd1);
    check("wd_left_held", 32'(audio_left), 32'h0013_579B);
    check("wd_right_held", 32'(audio_right), 32'h0024_68AC);
    s0 = strobes;
    send_word(1'b0, 32'h0011_1111, 24, 1'b1);
    send_word(1'b1, 32'h0022_2222, 24, 1'b0);
    check("wd_error_still_set", 32'(rx_error), 32'd1);
    check("wd_resync_left_held", 32'(audio_left), 32'h0013_579B);
    send_word(1'b0, 32'h0033_3333, 24, 1'b1);
    check("wd_error_cleared", 32'(rx_error), 32'd0);
    check("wd_no_strobe_yet", 32'(strobes - s0), 32'd0);
    push(24'h333333, 24'h444444);
    send_word(1'b1, 32'h0044_4444, 24, 1'b0);
    check("wd_strobe_back", 32'(strobes - s0), 32'd1);
`else
    check("stall_error_low", 32'(rx_error), 32'd0);
    check("stall_left_held", 32'(audio_left), 32'h0013_579B);
    check("stall_right_held", 32'(audio_right), 32'h0024_68AC);
`endif

    wait_cyc(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
